// File: rtl/seq_reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NUM_REQ requesters.
// Each requester writes data or clears to zero; pending clears outrank pending writes.
module seq_reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_clr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           q,
  output logic                       q_upd,
  output logic [$clog2(NUM_REQ)-1:0] q_src
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_after_gnt;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] cand_clr;
  logic [NUM_REQ-1:0] cand_wr;
  logic [IDX_W-1:0]   pick_ptr;
  pick_t              pick_clr;
  pick_t              pick_wr;
  pick_t              winner;

  logic             xfer;
  logic             xfer_clr;
  logic [WIDTH-1:0] xfer_data;

  // Pointer increment that wraps at NUM_REQ-1, so a non-power-of-two
  // requester count never produces an out-of-range index.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
    if (32'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // First set bit of mask at or after ptr, wrapping around.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] mask,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t       res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!res.found && mask[pos[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[IDX_W-1:0];
      end
    end
    return res;
  endfunction

  assign ptr_after_gnt = inc_wrap(gnt_idx);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cand     = req_valid;
    pick_ptr = rr_ptr;
    if (state == GRANT) begin
      // The requester just served is excluded, and the search starts from the
      // pointer value this grant will leave behind.
      cand[gnt_idx] = 1'b0;
      pick_ptr      = ptr_after_gnt;
    end
    cand_clr = cand & req_clr;
    cand_wr  = cand & ~req_clr;
  end

  assign pick_clr = rr_pick(cand_clr, pick_ptr);
  assign pick_wr  = rr_pick(cand_wr, pick_ptr);
  assign winner   = pick_clr.found ? pick_clr : pick_wr;

  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer      = (state == GRANT) && req_valid[gnt_idx];
  assign xfer_clr  = req_clr[gnt_idx];
  assign xfer_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    case (state)
      IDLE: begin
        if (winner.found) begin
          state_nxt   = GRANT;
          gnt_idx_nxt = winner.idx;
        end
      end
      GRANT: begin
        if (winner.found) begin
          gnt_idx_nxt = winner.idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_idx_nxt;
      // The pointer advances on every grant, even when the requester withdrew.
      if (state == GRANT) rr_ptr <= ptr_after_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      q_upd <= 1'b0;
      q_src <= '0;
    end else begin
      q_upd <= xfer;
      if (xfer) begin
        q     <= xfer_clr ? '0 : xfer_data;
        q_src <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_seq_reg_write_arbiter.sv
// Directed self-checking bench for seq_reg_write_arbiter (NUM_REQ=4, WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_seq_reg_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_clr;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         q;
  logic                     q_upd;
  logic [1:0]               q_src;

  int checks = 0;
  int errors = 0;

  seq_reg_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_clr   (req_clr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q         (q),
    .q_upd     (q_upd),
    .q_src     (q_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic c, input logic [WIDTH-1:0] d);
    req_valid[i] = v;
    req_clr[i]   = c;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_clr   = '0;
    req_data  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [7:0] rr_q   [5];
  logic [3:0] rr_rdy [5];

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_clr   = '0;
    req_data  = 32'h13121110;

    // Reset held two cycles with every requester valid.
    step();
    check("rst1_ready", 32'(req_ready), 32'h0);
    check("rst1_q",     32'(q),         32'h0);
    check("rst1_upd",   32'(q_upd),     32'h0);
    step();
    check("rst2_ready", 32'(req_ready), 32'h0);
    check("rst2_q",     32'(q),         32'h0);
    check("rst2_upd",   32'(q_upd),     32'h0);
    rst = 1'b0;
    step();
    check("rst_after_q",     32'(q),         32'h0);
    check("rst_after_upd",   32'(q_upd),     32'h0);
    check("rst_after_ready", 32'(req_ready), 32'h1);

    // Single write from requester 2.
    do_reset();
    set_req(2, 1'b1, 1'b0, 8'hA5);
    step();
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_upd0",  32'(q_upd),     32'h0);
    step();
    check("single_q",     32'(q),         32'hA5);
    check("single_upd",   32'(q_upd),     32'h1);
    check("single_src",   32'(q_src),     32'h2);
    check("single_idle",  32'(req_ready), 32'h0);
    set_req(2, 1'b0, 1'b0, 8'h00);
    step();
    check("single_upd_off", 32'(q_upd), 32'h0);
    check("single_q_hold",  32'(q),     32'hA5);

    // Round-robin with all four writing continuously.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 8'(8'h10 + i));
    step();
    check("rr_first_ready", 32'(req_ready), 32'h1);
    rr_q[0] = 8'h10; rr_rdy[0] = 4'b0010;
    rr_q[1] = 8'h11; rr_rdy[1] = 4'b0100;
    rr_q[2] = 8'h12; rr_rdy[2] = 4'b1000;
    rr_q[3] = 8'h13; rr_rdy[3] = 4'b0001;
    rr_q[4] = 8'h10; rr_rdy[4] = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr%0d_q", k),     32'(q),         32'(rr_q[k]));
      check($sformatf("rr%0d_src", k),   32'(q_src),     32'(k % 4));
      check($sformatf("rr%0d_upd", k),   32'(q_upd),     32'h1);
      check($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(rr_rdy[k]));
    end

    // Clear outranks a simultaneous write.
    do_reset();
    set_req(1, 1'b1, 1'b0, 8'h5A);
    step();
    step();
    check("clrp_pre_q", 32'(q), 32'h5A);
    set_req(1, 1'b0, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b0, 8'h77);
    set_req(3, 1'b1, 1'b1, 8'hEE);
    step();
    check("clrp_ready3", 32'(req_ready), 32'h8);
    step();
    check("clrp_q0",     32'(q),         32'h00);
    check("clrp_src3",   32'(q_src),     32'h3);
    check("clrp_upd",    32'(q_upd),     32'h1);
    check("clrp_ready0", 32'(req_ready), 32'h1);
    set_req(3, 1'b0, 1'b0, 8'h00);
    step();
    check("clrp_q77",    32'(q),         32'h77);
    check("clrp_src0",   32'(q_src),     32'h0);
    check("clrp_idle",   32'(req_ready), 32'h0);
    set_req(0, 1'b0, 1'b0, 8'h00);

    // Requester 1 withdraws during its grant; pointer still moves past it.
    do_reset();
    set_req(1, 1'b1, 1'b0, 8'h33);
    step();
    check("drop_ready1", 32'(req_ready), 32'h2);
    set_req(1, 1'b0, 1'b0, 8'h33);
    set_req(0, 1'b1, 1'b0, 8'h44);
    set_req(2, 1'b1, 1'b0, 8'h55);
    step();
    check("drop_q",      32'(q),         32'h00);
    check("drop_upd",    32'(q_upd),     32'h0);
    check("drop_src",    32'(q_src),     32'h0);
    check("drop_ready2", 32'(req_ready), 32'h4);
    step();
    check("drop_q55",    32'(q),         32'h55);
    check("drop_src2",   32'(q_src),     32'h2);
    check("drop_ready0", 32'(req_ready), 32'h1);
    set_req(2, 1'b0, 1'b0, 8'h00);
    step();
    check("drop_q44",    32'(q),         32'h44);
    check("drop_src0",   32'(q_src),     32'h0);
    set_req(0, 1'b0, 1'b0, 8'h00);

    // Reset asserted while requester 1 is granted.
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h5A);
    step();
    step();
    check("rstg_pre_q", 32'(q), 32'h5A);
    set_req(0, 1'b0, 1'b0, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'hFF);
    step();
    check("rstg_ready1", 32'(req_ready), 32'h2);
    rst = 1'b1;
    step();
    check("rstg_q",      32'(q),         32'h00);
    check("rstg_upd",    32'(q_upd),     32'h0);
    check("rstg_ready",  32'(req_ready), 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step();
    check("rstg_idle_ready", 32'(req_ready), 32'h0);
    check("rstg_idle_q",     32'(q),         32'h00);
    check("rstg_idle_upd",   32'(q_upd),     32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
